// File: rtl/garage_pkg.sv
// rtl/garage_pkg.sv - shared state encoding and default constants for the garage door blocks
package garage_pkg;

   typedef enum logic [1:0] {
      GS_IDLE  = 2'd0,
      GS_UP    = 2'd1,
      GS_DN    = 2'd2,
      GS_FAULT = 2'd3
   } garage_state_e;

   localparam int DEF_TRAVEL      = 10;
   localparam int DEF_POS_W       = 4;
   localparam int DEF_OVERRUN_LIM = 4;

endpackage

// File: rtl/garage_sat_counter.sv
// rtl/garage_sat_counter.sv - clamped up/down position counter with registered at-min/at-max flags
module garage_sat_counter #(
   parameter int W    = 4,
   parameter int MAX  = 10,
   parameter int INIT = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         up,
   output logic [W-1:0] count,
   output logic         at_min,
   output logic         at_max
);

   localparam logic [W-1:0] MAX_V  = MAX[W-1:0];
   localparam logic [W-1:0] INIT_V = INIT[W-1:0];

   logic [W-1:0] count_n;

   always_comb begin
      count_n = count;
      if (en && up && count != MAX_V)
         count_n = count + 1'b1;
      else if (en && !up && count != '0)
         count_n = count - 1'b1;
   end

   // Flags come from the next value so they change on the same edge as count.
   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= INIT_V;
         at_min <= (INIT_V == '0);
         at_max <= (INIT_V == MAX_V);
      end else begin
         count  <= count_n;
         at_min <= (count_n == '0);
         at_max <= (count_n == MAX_V);
      end
   end

endmodule

// File: rtl/garage_door_plant.sv
// rtl/garage_door_plant.sv - synthesizable garage door plant closing the loop for garage_control
module garage_door_plant
   import garage_pkg::*;
#(
   parameter int TRAVEL      = DEF_TRAVEL,
   parameter int POS_W       = DEF_POS_W,
   parameter int START_POS   = 0,
   parameter int OVERRUN_LIM = DEF_OVERRUN_LIM
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             UP_M,
   input  logic             DN_M,
   input  logic             obstruct,
   output logic             UP_Max,
   output logic             DN_Max,
   output logic [POS_W-1:0] position,
   output logic             moving,
   output logic             fault
);

   localparam logic [1:0] S_IDLE  = GS_IDLE;
   localparam logic [1:0] S_UP    = GS_UP;
   localparam logic [1:0] S_DN    = GS_DN;
   localparam logic [1:0] S_FAULT = GS_FAULT;

   localparam int OW = (OVERRUN_LIM < 2) ? 1 : $clog2(OVERRUN_LIM + 1);
   localparam logic [OW-1:0] OVR_LAST = OW'(OVERRUN_LIM - 1);

   logic [1:0]    state, state_n;
   logic [OW-1:0] ovr, ovr_n;
   logic          mv_up, mv_dn;

   always_comb begin
      state_n = state;
      ovr_n   = '0;
      mv_up   = 1'b0;
      mv_dn   = 1'b0;
      case (state)
         S_IDLE: begin
            if (UP_M && DN_M) state_n = S_FAULT;
            else if (UP_M)    state_n = S_UP;
            else if (DN_M)    state_n = S_DN;
         end
         S_UP: begin
            if (DN_M)           state_n = S_FAULT;
            else if (!UP_M)     state_n = S_IDLE;
            else if (UP_Max) begin
               // Pushing against the open limit; an obstructed door is not pushing.
               ovr_n = ovr;
               if (!obstruct) begin
                  if (ovr == OVR_LAST) state_n = S_FAULT;
                  else                 ovr_n = ovr + 1'b1;
               end
            end else
               mv_up = !obstruct;
         end
         S_DN: begin
            if (UP_M)           state_n = S_FAULT;
            else if (!DN_M)     state_n = S_IDLE;
            else if (DN_Max) begin
               ovr_n = ovr;
               if (!obstruct) begin
                  if (ovr == OVR_LAST) state_n = S_FAULT;
                  else                 ovr_n = ovr + 1'b1;
               end
            end else
               mv_dn = !obstruct;
         end
         default: state_n = S_FAULT;
      endcase
      if (state_n == S_FAULT) ovr_n = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         ovr    <= '0;
         moving <= 1'b0;
         fault  <= 1'b0;
      end else begin
         state  <= state_n;
         ovr    <= ovr_n;
         moving <= mv_up | mv_dn;
         fault  <= (state_n == S_FAULT);
      end
   end

   garage_sat_counter #(
      .W    (POS_W),
      .MAX  (TRAVEL),
      .INIT (START_POS)
   ) u_pos (
      .clk    (clk),
      .rst    (rst),
      .en     (mv_up | mv_dn),
      .up     (mv_up),
      .count  (position),
      .at_min (DN_Max),
      .at_max (UP_Max)
   );

endmodule

// File: tb/tb_garage_door_plant.sv
// tb/tb_garage_door_plant.sv - directed and randomized checks of garage_door_plant against a behavioural model
module tb_garage_door_plant;

   localparam int TRAVEL = 10;
   localparam int LIM    = 4;
   localparam int START  = 0;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       UP_M = 1'b0;
   logic       DN_M = 1'b0;
   logic       obstruct = 1'b0;
   logic       UP_Max, DN_Max, moving, fault;
   logic [3:0] position;

   int checks = 0;
   int failures = 0;

   // Behavioural model: direction of travel, a door position, a push tally.
   int  m_pos = START;
   int  m_dir = 0;
   int  m_push = 0;
   bit  m_fault = 0;
   bit  m_moving = 0;
   bit  m_valid = 0;

   garage_door_plant #(
      .TRAVEL      (TRAVEL),
      .POS_W       (4),
      .START_POS   (START),
      .OVERRUN_LIM (LIM)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .UP_M     (UP_M),
      .DN_M     (DN_M),
      .obstruct (obstruct),
      .UP_Max   (UP_Max),
      .DN_Max   (DN_Max),
      .position (position),
      .moving   (moving),
      .fault    (fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      m_moving = 0;
      if (rst) begin
         m_pos = START; m_dir = 0; m_push = 0; m_fault = 0; m_valid = 1;
      end else if (!m_fault) begin
         if (UP_M && DN_M) begin
            m_fault = 1;
         end else if (m_dir == 0) begin
            m_dir = UP_M ? 1 : (DN_M ? -1 : 0);
            m_push = 0;
         end else if ((m_dir == 1 && !UP_M) || (m_dir == -1 && !DN_M)) begin
            if (UP_M || DN_M) m_fault = 1;
            else begin m_dir = 0; m_push = 0; end
         end else if ((m_dir == 1 && m_pos == TRAVEL) || (m_dir == -1 && m_pos == 0)) begin
            if (!obstruct) begin
               m_push++;
               if (m_push == LIM) m_fault = 1;
            end
         end else begin
            m_push = 0;
            if (!obstruct) begin
               m_pos += m_dir;
               m_moving = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("position", position, m_pos);
         check("UP_Max", UP_Max, m_pos == TRAVEL);
         check("DN_Max", DN_Max, m_pos == 0);
         check("moving", moving, m_moving);
         check("fault", fault, m_fault);
      end
   end

   task automatic drive(input bit u, input bit d, input bit o, input bit r, input int n);
      UP_M = u; DN_M = d; obstruct = o; rst = r;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int cmd;
      @(negedge clk);
      drive(0, 0, 0, 1, 2);
      check("reset_pos", position, 0);
      check("reset_dnmax", DN_Max, 1);
      check("reset_upmax", UP_Max, 0);
      check("reset_fault", fault, 0);
      check("reset_moving", moving, 0);

      drive(1, 0, 0, 0, 1);
      check("start_edge_pos", position, 0);
      check("start_edge_dnmax", DN_Max, 1);
      drive(1, 0, 0, 0, 1);
      check("edge1_pos", position, 1);
      check("edge1_dnmax", DN_Max, 0);
      drive(1, 0, 0, 0, 9);
      check("edge10_upmax", UP_Max, 1);
      drive(1, 0, 0, 0, 3);
      check("open_pos", position, 10);
      check("open_fault", fault, 0);
      drive(1, 0, 0, 0, 1);
      check("overrun_fault", fault, 1);
      check("overrun_pos", position, 10);
      check("overrun_moving", moving, 0);
      drive(0, 0, 0, 1, 1);
      check("clear_pos", position, 0);
      check("clear_dnmax", DN_Max, 1);
      check("clear_fault", fault, 0);

      drive(1, 0, 0, 0, 6);
      check("half_pos", position, 5);
      drive(0, 0, 0, 0, 1);
      drive(0, 1, 0, 0, 1);
      check("dead_edge_pos", position, 5);
      check("dead_edge_moving", moving, 0);
      drive(0, 1, 0, 0, 4);
      check("close4_pos", position, 1);
      check("close4_dnmax", DN_Max, 0);
      drive(0, 1, 0, 0, 1);
      check("closed_pos", position, 0);
      check("closed_dnmax", DN_Max, 1);

      drive(0, 0, 0, 0, 1);
      drive(1, 0, 0, 0, 5);
      check("pre_obs_pos", position, 4);
      drive(1, 0, 1, 0, 3);
      check("obs_pos", position, 4);
      check("obs_moving", moving, 0);
      check("obs_fault", fault, 0);
      drive(1, 0, 0, 0, 1);
      check("resume_pos", position, 5);
      check("resume_moving", moving, 1);

      drive(0, 0, 0, 0, 1);
      drive(1, 1, 0, 0, 1);
      check("both_fault", fault, 1);
      check("both_pos", position, 5);

      drive(0, 0, 0, 1, 1);
      drive(1, 0, 0, 0, 8);
      check("mid_pos", position, 7);
      drive(1, 0, 0, 1, 1);
      check("midrst_pos", position, START);
      check("midrst_moving", moving, 0);
      drive(1, 0, 0, 0, 1);
      check("midrst_idle_pos", position, START);

      cmd = 1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(7) == 0) begin
            cmd = $urandom_range(3);
            if (cmd == 3 && $urandom_range(3) != 0) cmd = 0;
         end
         drive(cmd == 1 || cmd == 3, cmd == 2 || cmd == 3,
               $urandom_range(5) == 0, $urandom_range(63) == 0, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/garage_door_plant.md
# garage_door_plant

Behavioural plant model of the garage door, driven by the motor commands of `garage_control`. It closes the loop for that controller: it consumes `UP_M`/`DN_M` and produces the `UP_Max`/`DN_Max` limit-switch signals the controller reads. It also reports door position and motion for checking. It is synthesizable, so it can sit in the system-level bench or in an FPGA demo beside the controller.

## Interface
- `TRAVEL`, default 10: cycles of motor drive from fully closed (0) to fully open (`TRAVEL`); legal range 2..2^POS_W-1
- `POS_W`, default 4: width of the position counter
- `START_POS`, default 0: position loaded at reset; 0..`TRAVEL`
- `OVERRUN_LIM`, default 4: consecutive cycles a motor may push against its own limit before fault; ≥1
- `clk`  in  1  single system clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `UP_M`  in  1  open-motor command from the controller
- `DN_M`  in  1  close-motor command from the controller
- `obstruct`  in  1  mechanical block; door cannot move while high
- `UP_Max`  out  1  open-limit switch; high when position == `TRAVEL`
- `DN_Max`  out  1  closed-limit switch; high when position == 0
- `position`  out  POS_W  current door position
- `moving`  out  1  position changed on the last edge
- `fault`  out  1  sticky plant fault

## Operation
- States: IDLE, UP, DN, FAULT.
- Reset (sync, `rst`=1 at an edge):
  - state = IDLE, position = `START_POS`
  - `UP_Max` = (`START_POS`==`TRAVEL`), `DN_Max` = (`START_POS`==0)
  - `moving` = 0, `fault` = 0, overrun counter = 0
  - Reset has priority over everything, including FAULT and mid-travel motion.
- IDLE:
  - `UP_M & ~DN_M` → UP
  - `DN_M & ~UP_M` → DN
  - `UP_M & DN_M` → FAULT
  - Otherwise stay in IDLE.
  - The position never changes in IDLE.
- UP:
  - `DN_M`=1 → FAULT, no movement.
  - `UP_M`=0 → IDLE, no movement.
  - Otherwise, if `obstruct`=0 and position < `TRAVEL`, position += 1.
- DN: mirror of UP.
  - `UP_M`=1 → FAULT.
  - `DN_M`=0 → IDLE.
  - Otherwise, if `obstruct`=0 and position > 0, position −= 1.
- Saturation:
  - The position never wraps; it clamps at 0 and `TRAVEL`.
  - In UP with position == `TRAVEL` and `UP_M`=1, the overrun counter increments each edge. Same in DN with position == 0 and `DN_M`=1.
  - The edge on which the counter would reach `OVERRUN_LIM` → FAULT.
  - The counter clears on any state change, and whenever the door is not at the pushed limit.
  - Obstruction does not count as overrun.
- FAULT:
  - Sticky until `rst`.
  - `fault`=1, `moving`=0.
  - Position and limit outputs hold their last values; all inputs are ignored.
- `obstruct` freezes the position only. State transitions still follow the motor commands.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- `UP_Max`/`DN_Max` are computed from the next position and update on the same edge as `position`.
- `moving` = 1 for exactly the cycle following an edge that changed `position`.
- Latency, full open from closed, `UP_M` held from the edge at cycle 0:
  - That edge: IDLE → UP, no movement.
  - Edges 1..`TRAVEL`: position increments.
  - `DN_Max` falls after edge 1.
  - `UP_Max` rises after edge `TRAVEL`.
- Command reversal through IDLE costs one dead edge, with no movement on the transition edge.
- Simultaneous `UP_M`/`DN_M` in any non-FAULT state → FAULT on that edge, with no movement.

## Structure
- Shared package `garage_pkg`:
  - state enum (IDLE/UP/DN/FAULT), also reused by `garage_control` checkers
  - default constants for `TRAVEL`, `POS_W`, `OVERRUN_LIM`
- One sub-module is natural: `garage_sat_counter`. It is an up/down counter with enable, clamp bounds 0..`TRAVEL`, sync load of `START_POS` on `rst`, and at-min/at-max flags.
- The FSM, overrun counter and output registers live in the top.

## Test plan
- Reset, then hold `UP_M`=1 for 14 cycles:
  - `DN_Max` falls after edge 1.
  - `UP_Max` rises after edge 10.
  - `position`=10, `fault`=0 at the end.
- `START_POS`=0, then `UP_M`=1 for 15+ cycles:
  - After reaching 10, four further edges pushing at the limit → `fault`=1.
  - `position` holds 10, `moving`=0.
  - `rst` clears: `position`=0, `DN_Max`=1.
- Open to 5, drop `UP_M` one cycle, then raise `DN_M`:
  - One dead edge at IDLE → DN.
  - Position then steps 5→0.
  - `DN_Max` rises after the 5th decrement.
- Assert `obstruct` for 3 cycles mid-travel at position 4 while `UP_M`=1:
  - Position stays 4 and `moving`=0 for those cycles.
  - No fault; motion resumes 4→5 on the first unobstructed edge.
- `UP_M`=`DN_M`=1 in IDLE → `fault`=1 after that edge, position unchanged.
- Assert `rst` mid-travel at position 7 → next cycle: position = `START_POS`, state IDLE, `moving`=0.
